// File: rtl/ps2_rx_scancode.sv
// PS/2 device-to-host receiver: deserializes 11-bit frames into scan codes with a previous-byte history.
// Optional macro PS2_CLK_FILTER_EN adds a FILTER_LEN-sample glitch filter on the synchronized ps2_clk.
module ps2_rx_scancode #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic [7:0] prev_code,
   output logic       code_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          clk_filt, clk_prev, fe, data_q;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          parity_bit;
   logic [TW-1:0] to_cnt;

   if (FILTER_LEN < 1) begin : g_filter_len_check
      $error("FILTER_LEN must be at least 1");
   end

   // Synchronizers reset high so an idle bus never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

`ifdef PS2_CLK_FILTER_EN
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   logic [FW-1:0] filt_cnt;

   // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
         clk_filt <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end
`else
   assign clk_filt = clk_s2;
`endif

   // Registered falling-edge strobe; data is delayed alongside it to stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_prev <= 1'b1;
         fe       <= 1'b0;
         data_q   <= 1'b1;
      end else begin
         clk_prev <= clk_filt;
         fe       <= clk_prev & ~clk_filt;
         data_q   <= data_s2;
      end
   end

   assign busy = (state != IDLE);

   // Frame FSM; a falling edge in the same cycle as the timeout wins over the abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         to_cnt     <= '0;
         scan_code  <= '0;
         prev_code  <= '0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (state == IDLE || fe) begin
            to_cnt <= '0;
         end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (fe && !data_q) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (fe) begin
                  shreg   <= {data_q, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (fe) begin
                  parity_bit <= data_q;
                  state      <= STOP;
               end
            end
            STOP: begin
               if (fe) begin
                  state <= IDLE;
                  if (data_q && ((^shreg) ^ parity_bit)) begin
                     prev_code  <= scan_code;
                     scan_code  <= shreg;
                     code_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (state != IDLE && !fe && to_cnt == TO_LAST) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Directed, table-driven bench for ps2_rx_scancode with a scaled-down PS/2 bit period and timeout.
module tb_ps2_rx_scancode;
   localparam int TO = 2000;
   localparam int FL = 8;
   localparam int Q  = 50;
   localparam int H  = 100;
`ifdef PS2_CLK_FILTER_EN
   localparam int LAT = 4 + FL;
`else
   localparam int LAT = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n, ps2_clk, ps2_data;
   logic [7:0] scan_code, prev_code;
   logic       code_valid, frame_err, busy;

   ps2_rx_scancode #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scan_code  (scan_code),
      .prev_code  (prev_code),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #10 clk = ~clk;

   int   compared = 0, mismatched = 0;
   int   cyc = 0, cvCount = 0, errCount = 0, overlapCount = 0, longCount = 0;
   int   lastCvCyc = 0, stopFallCyc = 0;
   logic cvPrev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled on the inactive edge.
   always @(negedge clk) begin
      if (code_valid) begin
         cvCount++;
         lastCvCyc = cyc;
         if (cvPrev) longCount++;
      end
      if (frame_err) errCount++;
      if (code_valid && frame_err) overlapCount++;
      cvPrev = code_valid;
   end

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stp;
      logic       expValid;
      logic [7:0] expScan;
      logic [7:0] expPrev;
   } vec_t;

   vec_t vecs[8];

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Sends the first nbits of a frame; glitchAfter >= 0 adds a 2-cycle low pulse after that bit's rising edge.
   task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stp,
                                input int nbits, input int glitchAfter);
      logic [10:0] frame;
      frame = {stp, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = frame[i];
         waitCycles(Q);
         ps2_clk = 1'b0;
         if (i == 10) stopFallCyc = cyc;
         waitCycles(H);
         ps2_clk = 1'b1;
         if (i == glitchAfter) begin
            waitCycles(10);
            ps2_clk = 1'b0;
            waitCycles(2);
            ps2_clk = 1'b1;
            waitCycles(Q - 12);
         end else begin
            waitCycles(Q);
         end
      end
      if (nbits == 11) ps2_data = 1'b1;
   endtask

   int cv0, e0;

   initial begin
      vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 8'h00};
      vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'h1C};
      vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 8'hF0};
      vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C, 8'hF0};
      vecs[4] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 8'hF0};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h1C};
      vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00};
      vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 8'hFF};

      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      waitCycles(5);
      checkOutput("reset scan_code", scan_code, 0);
      checkOutput("reset prev_code", prev_code, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset pulses", {code_valid, frame_err}, 0);
      rst_n = 1'b1;
      waitCycles(10);

      for (int i = 0; i < 8; i++) begin
         cv0 = cvCount;
         e0  = errCount;
         applyStimulus(vecs[i].d, vecs[i].par, vecs[i].stp, 11, -1);
         waitCycles(40);
         checkOutput($sformatf("vec%0d code_valid pulses", i), cvCount - cv0, vecs[i].expValid ? 1 : 0);
         checkOutput($sformatf("vec%0d frame_err pulses", i), errCount - e0, vecs[i].expValid ? 0 : 1);
         checkOutput($sformatf("vec%0d scan_code", i), scan_code, vecs[i].expScan);
         checkOutput($sformatf("vec%0d prev_code", i), prev_code, vecs[i].expPrev);
         checkOutput($sformatf("vec%0d busy", i), busy, 0);
         if (vecs[i].expValid)
            checkOutput($sformatf("vec%0d latency", i), lastCvCyc - stopFallCyc, LAT);
      end

      // Back-to-back frames with no idle gap.
      cv0 = cvCount;
      e0  = errCount;
      applyStimulus(8'h34, 1'b0, 1'b1, 11, -1);
      applyStimulus(8'h21, 1'b1, 1'b1, 11, -1);
      waitCycles(40);
      checkOutput("b2b code_valid pulses", cvCount - cv0, 2);
      checkOutput("b2b frame_err pulses", errCount - e0, 0);
      checkOutput("b2b scan_code", scan_code, 8'h21);
      checkOutput("b2b prev_code", prev_code, 8'h34);

      // Partial frame abandoned mid-way: timeout abort.
      cv0 = cvCount;
      e0  = errCount;
      applyStimulus(8'h00, 1'b0, 1'b1, 4, -1);
      waitCycles(10);
      checkOutput("timeout busy before", busy, 1);
      waitCycles(TO + 50);
      checkOutput("timeout frame_err pulses", errCount - e0, 1);
      checkOutput("timeout code_valid pulses", cvCount - cv0, 0);
      checkOutput("timeout busy after", busy, 0);
      applyStimulus(8'h12, 1'b1, 1'b1, 11, -1);
      waitCycles(40);
      checkOutput("post-timeout scan_code", scan_code, 8'h12);
      checkOutput("post-timeout prev_code", prev_code, 8'h21);
      checkOutput("post-timeout code_valid pulses", cvCount - cv0, 1);

      // Short glitch on ps2_clk right after D0.
      cv0 = cvCount;
      e0  = errCount;
      applyStimulus(8'h29, 1'b0, 1'b1, 11, 1);
      waitCycles(40);
`ifdef PS2_CLK_FILTER_EN
      checkOutput("glitch scan_code", scan_code, 8'h29);
      checkOutput("glitch frame_err pulses", errCount - e0, 0);
      checkOutput("glitch code_valid pulses", cvCount - cv0, 1);
`else
      checkOutput("glitch scan_code", scan_code, 8'h12);
      checkOutput("glitch frame_err pulses", errCount - e0, 1);
      checkOutput("glitch code_valid pulses", cvCount - cv0, 0);
`endif
      checkOutput("glitch busy", busy, 0);

      // Reset in the middle of a frame.
      applyStimulus(8'h5A, 1'b1, 1'b1, 6, -1);
      waitCycles(5);
      checkOutput("midreset busy before", busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset scan_code", scan_code, 0);
      checkOutput("midreset prev_code", prev_code, 0);
      checkOutput("midreset busy", busy, 0);
      checkOutput("midreset pulses", {code_valid, frame_err}, 0);
      waitCycles(3);
      rst_n = 1'b1;
      waitCycles(10);
      cv0 = cvCount;
      e0  = errCount;
      applyStimulus(8'h5A, 1'b1, 1'b1, 11, -1);
      waitCycles(40);
      checkOutput("post-reset scan_code", scan_code, 8'h5A);
      checkOutput("post-reset prev_code", prev_code, 8'h00);
      checkOutput("post-reset code_valid pulses", cvCount - cv0, 1);
      checkOutput("post-reset frame_err pulses", errCount - e0, 0);

      checkOutput("valid/err overlap cycles", overlapCount, 0);
      checkOutput("code_valid wider than one cycle", longCount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ps2_rx_scancode.md
Name: ps2_rx_scancode

Overview:
- Receives the raw PS/2 keyboard interface: open-collector ps2_clk/ps2_data driven by the keyboard, 10–16.7 kHz.
- Deserializes 11-bit device-to-host frames into 8-bit scan codes.
- Presents the current and previous bytes to the downstream scan-code-to-ASCII stage, plus a one-cycle strobe per accepted byte.
- Sits between the board PS/2 pins and the keyboard decode logic.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles allowed between successive ps2_clk falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered ps2_clk changes level. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous to clk
- ps2_data  input  1  raw PS/2 data from pin, asynchronous to clk
- scan_code  output  8  most recently accepted byte
- prev_code  output  8  byte accepted before scan_code
- code_valid  output  1  one-cycle pulse; scan_code/prev_code updated this cycle
- frame_err  output  1  one-cycle pulse on a rejected or aborted frame
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, async): scan_code=0x00, prev_code=0x00, code_valid=0, frame_err=0, busy=0; state=IDLE; shift register, bit counter and timeout counter cleared. Reset mid-frame discards the partial frame; nothing is emitted.
- Synchronization: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- Edge detect: a falling edge (fe) is registered when the synchronized clock goes prev=1, cur=0. All sampling uses synchronized data on fe cycles only.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0, go to DATA with bit_cnt=0. On fe with data=1, stay in IDLE and ignore it.
  - DATA: on fe, shift data into bit 7 of shreg (shreg >> 1) and increment bit_cnt. After the 8th bit go to PARITY.
  - PARITY: on fe, latch parity bit and go to STOP.
  - STOP: on fe, evaluate the frame and return to IDLE.
    - Accept: stop=1 and XOR(shreg, parity)=1. Then prev_code<=scan_code, scan_code<=shreg, code_valid=1 for exactly one cycle (the cycle after the fe cycle).
    - Reject: otherwise, frame_err=1 for one cycle; scan_code and prev_code unchanged.
- Latency: code_valid asserts 4 clk cycles after the raw ps2_clk falling edge of the stop bit: 2 sync + 1 edge register + 1 output register.
- Timeout:
  - Counter clears on every fe and whenever the state is IDLE; it increments otherwise and saturates.
  - If the state is not IDLE and the counter reaches TIMEOUT_CYCLES-1, go to IDLE and pulse frame_err.
  - If fe and timeout coincide in the same cycle, the fe is processed and timeout is not taken.
- code_valid and frame_err are never high in the same cycle; both are registered outputs.
- No host-to-device transmission; ps2_clk and ps2_data are inputs only.
- Back-to-back frames with no idle gap are accepted. The start bit may follow the stop edge directly.

Optional Feature:
- PS2_CLK_FILTER_EN defined:
  - A glitch filter sits between the synchronizer and the edge detector.
  - The filtered clock changes only after FILTER_LEN consecutive identical synchronized samples; pulses shorter than FILTER_LEN cycles are ignored.
  - Filtered clock resets to 1.
  - Latency to code_valid grows by FILTER_LEN cycles.
- Undefined: no filter; FILTER_LEN is unused; latency is as stated above.

Test Plan:
- Frame 0x1C, parity 0, stop 1 (PS/2 clock period 80 us) -> one code_valid pulse, scan_code=0x1C, prev_code=0x00, frame_err stays 0.
- Frame 0xF0 (parity 1), then frame 0x1C (parity 0) -> two code_valid pulses; final scan_code=0x1C, prev_code=0xF0.
- Frame 0x1C with parity 1 -> frame_err one-cycle pulse, no code_valid, scan_code/prev_code unchanged. Repeat with stop bit 0 -> same response.
- Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, busy falls. A following 0x12 frame (parity 1) -> scan_code=0x12.
- rst_n pulsed low after 5 data bits of 0x5A -> all outputs 0 and busy=0 immediately. A following complete 0x5A frame (parity 1) -> scan_code=0x5A, prev_code=0x00.
- With PS2_CLK_FILTER_EN: 2-cycle low glitches injected on ps2_clk during frame 0x29 (parity 0) -> scan_code=0x29, no frame_err. Without the macro, the same stimulus -> frame_err or wrong code (negative check).
